// File: rtl/blink_code_sched_if.sv
// rtl/blink_code_sched_if.sv - request/code inputs and blink/grant/status outputs of the blink code scheduler
interface blink_code_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*CODE_W-1:0] code;
    logic                      led;
    logic [NUM_REQ-1:0]        grant;
    logic                      done;
    logic                      busy;
    logic [31:0]               codes_sent_cnt;

    modport master (
        output req, code,
        input  led, grant, done, busy, codes_sent_cnt
    );

    modport slave (
        input  req, code,
        output led, grant, done, busy, codes_sent_cnt
    );
endinterface

// File: rtl/blink_code_sched.sv
// rtl/blink_code_sched.sv - non-preemptive blink code scheduler for a shared debug LED (option: BLINK_CODE_SCHED_STRICT_PRIO_EN selects fixed priority)
module blink_code_sched #(
    parameter int          NUM_REQ         = 4,
    parameter int          CODE_W          = 4,
    parameter logic [31:0] PULSE_LEN_COUNT = 32'h007A_1200,
    parameter logic [31:0] INTER_CODE_GAP  = 32'h00F4_2400
) (
    input logic               clk,
    input logic               rst,
    blink_code_sched_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                led_q, led_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [31:0]         cnt_sent_q, cnt_sent_d;
    logic [31:0]         cyc_cnt_q, cyc_cnt_d;
    logic [CODE_W-1:0]   code_lat_q, code_lat_d;
    logic [CODE_W-1:0]   pulse_idx_q, pulse_idx_d;
    logic [CODE_W-1:0]   pulse_nxt;

    logic [NUM_REQ-1:0]  eligible;
    logic                any_elig;
    logic [PTR_W-1:0]    win_idx;
    logic [CODE_W-1:0]   win_code;

`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_lat_q, win_lat_d;
`endif

    // A requester with a zero code has nothing to show, so it is masked out.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req[i] && (bus.code[i*CODE_W +: CODE_W] != '0);
        end
    end

    assign any_elig = |eligible;

`ifdef BLINK_CODE_SCHED_STRICT_PRIO_EN
    // Fixed priority: scan downward so the lowest eligible index is the last written.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end
`else
    // Round-robin: first eligible requester at or after the pointer, wrapping.
    always_comb begin
        logic found;
        int   j;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && eligible[j]) begin
                win_idx = PTR_W'(j);
                found   = 1'b1;
            end
        end
    end
`endif

    assign win_code  = bus.code[win_idx*CODE_W +: CODE_W];
    assign pulse_nxt = pulse_idx_q + 1'b1;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        grant_d     = grant_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        cnt_sent_d  = cnt_sent_q;
        cyc_cnt_d   = cyc_cnt_q + 32'd1;
        code_lat_d  = code_lat_q;
        pulse_idx_d = pulse_idx_q;
`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
        win_lat_d   = win_lat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cyc_cnt_d = '0;
                if (any_elig) begin
                    state_d     = ST_ON;
                    code_lat_d  = win_code;
                    grant_d     = NUM_REQ'(1) << win_idx;
                    busy_d      = 1'b1;
                    led_d       = 1'b1;
                    pulse_idx_d = '0;
`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
                    win_lat_d   = win_idx;
`endif
                end
            end
            ST_ON: begin
                if (cyc_cnt_q == PULSE_LEN_COUNT - 32'd1) begin
                    cyc_cnt_d   = '0;
                    pulse_idx_d = pulse_nxt;
                    led_d       = 1'b0;
                    state_d     = (pulse_nxt == code_lat_q) ? ST_GAP : ST_OFF;
                end
            end
            ST_OFF: begin
                if (cyc_cnt_q == PULSE_LEN_COUNT - 32'd1) begin
                    cyc_cnt_d = '0;
                    led_d     = 1'b1;
                    state_d   = ST_ON;
                end
            end
            ST_GAP: begin
                if (cyc_cnt_q == INTER_CODE_GAP - 32'd1) begin
                    cyc_cnt_d  = '0;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cnt_sent_d = cnt_sent_q + 32'd1;
                    state_d    = ST_IDLE;
`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
                    if (win_lat_q == PTR_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_lat_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any code in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            led_q       <= 1'b0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cnt_sent_q  <= '0;
            cyc_cnt_q   <= '0;
            code_lat_q  <= '0;
            pulse_idx_q <= '0;
`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
            rr_ptr_q    <= '0;
            win_lat_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            if (state_q == ST_GAP && done_d) begin
                cnt_sent_q <= cnt_sent_d;
            end
            cyc_cnt_q   <= cyc_cnt_d;
            code_lat_q  <= code_lat_d;
            pulse_idx_q <= pulse_idx_d;
`ifndef BLINK_CODE_SCHED_STRICT_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
            win_lat_q   <= win_lat_d;
`endif
        end
    end

    assign bus.led            = led_q;
    assign bus.grant          = grant_q;
    assign bus.done           = done_q;
    assign bus.busy           = busy_q;
    assign bus.codes_sent_cnt = cnt_sent_q;

endmodule

// File: tb/tb_blink_code_sched.sv
// tb/tb_blink_code_sched.sv - scoreboard bench for blink_code_sched with short pulse and gap lengths
module tb_blink_code_sched;
    localparam int PL = 4;
    localparam int GL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc_now = 0;
    int   exp_q[$];
    logic [3:0] prev_grant = '0;

    blink_code_sched_if #(.NUM_REQ(4), .CODE_W(4)) bif ();

    blink_code_sched #(
        .NUM_REQ(4),
        .CODE_W(4),
        .PULSE_LEN_COUNT(32'd4),
        .INTER_CODE_GAP(32'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_now++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_led(input int cyc, input int n);
        int t;
        t = cyc - 1;
        if (t < 0 || t >= (2 * n - 1) * PL) return 1'b0;
        return ((t / PL) % 2) == 0;
    endfunction

    // Scoreboard: each new grant is compared against the oldest expected winner.
    always @(negedge clk) begin
        if (bif.grant != 4'b0 && prev_grant == 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_grant", 32'(bif.grant), 32'h0);
            end else begin
                chk("sb_grant", 32'(bif.grant), 32'(4'b1 << exp_q.pop_front()));
            end
        end
        prev_grant = bif.grant;
    end

    // Inputs must already be driven; checks one whole frame cycle by cycle plus the done cycle.
    task automatic check_frame(input int win, input int n, input int drop_cyc,
                               input bit alter, input logic [31:0] exp_cnt);
        int frame;
        logic [3:0] g;
        frame = (2 * n - 1) * PL + GL;
        g = 4'b1 << win;
        for (int c = 1; c <= frame + 1; c++) begin
            @(negedge clk);
            if (c <= frame) begin
                chk($sformatf("led_n%0d_c%0d", n, c), 32'(bif.led), 32'(exp_led(c, n)));
                chk($sformatf("grant_n%0d_c%0d", n, c), 32'(bif.grant), 32'(g));
                chk($sformatf("busy_n%0d_c%0d", n, c), 32'(bif.busy), 32'h1);
                chk($sformatf("done_n%0d_c%0d", n, c), 32'(bif.done), 32'h0);
                if (c == 1) chk("cnt_before", bif.codes_sent_cnt, exp_cnt - 32'd1);
            end else begin
                chk($sformatf("done_end_n%0d", n), 32'(bif.done), 32'h1);
                chk($sformatf("grant_end_n%0d", n), 32'(bif.grant), 32'h0);
                chk($sformatf("busy_end_n%0d", n), 32'(bif.busy), 32'h0);
                chk($sformatf("led_end_n%0d", n), 32'(bif.led), 32'h0);
                chk($sformatf("cnt_end_n%0d", n), bif.codes_sent_cnt, exp_cnt);
            end
            if (c == drop_cyc) begin
                bif.req = 4'b0000;
                if (alter) bif.code[3:0] = 4'd1;
            end
        end
        @(negedge clk);
        chk($sformatf("done_clear_n%0d", n), 32'(bif.done), 32'h0);
    endtask

    initial begin
        int waited;
        int last_done;
        int ndone;

        bif.req  = 4'b0000;
        bif.code = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(bif.led), 32'h0);
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_done", 32'(bif.done), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_cnt", bif.codes_sent_cnt, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // single code of 3 from requester 0
        bif.req = 4'b0001;
        bif.code = 16'h0003;
        exp_q.push_back(0);
        check_frame(0, 3, 1, 1'b0, 32'd1);

        // code 0 on requester 0 is masked; requester 1 with code 2 wins
        bif.req = 4'b0011;
        bif.code = 16'h0020;
        exp_q.push_back(1);
        check_frame(1, 2, 1, 1'b0, 32'd2);

        // req drop and code change mid-code are ignored
        bif.req = 4'b0001;
        bif.code = 16'h0005;
        exp_q.push_back(0);
        check_frame(0, 5, 6, 1'b1, 32'd3);

        // reset mid-code aborts with no done pulse
        bif.req = 4'b0001;
        bif.code = 16'h0003;
        exp_q.push_back(0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("t5_led_c%0d", c), 32'(bif.led), 32'(exp_led(c, 3)));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t5_led", 32'(bif.led), 32'h0);
        chk("t5_grant", 32'(bif.grant), 32'h0);
        chk("t5_busy", 32'(bif.busy), 32'h0);
        chk("t5_done", 32'(bif.done), 32'h0);
        chk("t5_cnt", bif.codes_sent_cnt, 32'h0);
        bif.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bif.done) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'h0);
        chk("t5_cnt_after", bif.codes_sent_cnt, 32'h0);

        // counter wrap
        force dut.cnt_sent_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_sent_q;
        @(negedge clk);
        chk("t6_cnt_forced", bif.codes_sent_cnt, 32'hFFFF_FFFF);
        bif.req = 4'b0001;
        bif.code = 16'h0001;
        exp_q.push_back(0);
        check_frame(0, 1, 1, 1'b0, 32'h0);

        // round-robin with requesters 0,1,3 held high, all codes 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif.req = 4'b1011;
        bif.code = 16'h1111;
        for (int k = 0; k < 2; k++) begin
`ifdef BLINK_CODE_SCHED_STRICT_PRIO_EN
            exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
`endif
        end
        last_done = 0;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            @(negedge clk);
            while (!bif.done && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk($sformatf("t2_done_seen_%0d", k), 32'(bif.done), 32'h1);
            if (k > 0) chk($sformatf("t2_interval_%0d", k), 32'(cyc_now - last_done), 32'd13);
            last_done = cyc_now;
            if (k == 5) bif.req = 4'b0000;
        end
        repeat (3) @(negedge clk);
        chk("t2_cnt", bif.codes_sent_cnt, 32'd6);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
